// File: rtl/filt_mac_accum_if.sv
// Stream bundle for filt_mac_accum: tap-product input, output sample, control and status.
// slave is the accumulator side; master is the producer/consumer side.
interface filt_mac_accum_if #(
    parameter int unsigned DATA_W = 32
);
    logic              clear;
    logic [DATA_W-1:0] prod_data;
    logic              prod_valid;
    logic              prod_ready;
    logic [DATA_W-1:0] y_data;
    logic              y_valid;
    logic              y_ready;
    logic              busy;
    logic              sat_flag;

    modport master (output clear, prod_data, prod_valid, y_ready,
                    input  prod_ready, y_data, y_valid, busy, sat_flag);
    modport slave  (input  clear, prod_data, prod_valid, y_ready,
                    output prod_ready, y_data, y_valid, busy, sat_flag);
endinterface

// File: rtl/filt_mac_accum.sv
// FIR tap accumulator: sums NUM_TAPS signed products per output sample, valid/ready output.
// Define FILT_ACC_SAT_EN for a widened accumulator with output saturation and sticky sat_flag.
module filt_mac_accum #(
    parameter int unsigned NUM_TAPS = 11,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CNT_W    = $clog2(NUM_TAPS)
) (
    input logic             ap_clk,
    input logic             ap_rst_n,
    filt_mac_accum_if.slave bus
);
`ifdef FILT_ACC_SAT_EN
    localparam int unsigned ACC_W = DATA_W + CNT_W + 1;
`else
    localparam int unsigned ACC_W = DATA_W;
`endif
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

    typedef enum logic {ACCUM, HOLD} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0]        tap_cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic [DATA_W-1:0]       y_nxt;
    logic [DATA_W-1:0]       y_data;
    logic                    accept;
    logic                    y_hs;
    logic                    last_tap;

    assign accept   = bus.prod_valid && bus.prod_ready;
    assign y_hs     = bus.y_valid && bus.y_ready;
    assign last_tap = (tap_cnt == LAST_TAP);
    assign prod_ext = ACC_W'($signed(bus.prod_data));

    // Tap 0 loads rather than adds, so a new frame never sees the previous sum.
    assign sum = ((tap_cnt == '0) ? '0 : acc) + prod_ext;

`ifdef FILT_ACC_SAT_EN
    logic [ACC_W-DATA_W:0] sum_top;
    logic                  sat_hit;
    logic                  sat_q;

    // In range only when every bit above the output sign bit matches it.
    assign sum_top = sum[ACC_W-1:DATA_W-1];
    assign sat_hit = !((&sum_top) || !(|sum_top));

    always_comb begin
        y_nxt = sum[DATA_W-1:0];
        if (sat_hit)
            y_nxt = sum[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            sat_q <= 1'b0;
        else if (bus.clear)
            sat_q <= 1'b0;
        else if (accept && last_tap && sat_hit)
            sat_q <= 1'b1;
    end

    assign bus.sat_flag = sat_q;
`else
    assign y_nxt        = sum;
    assign bus.sat_flag = 1'b0;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            state <= ACCUM;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.clear)
            state_nxt = ACCUM;
        else begin
            case (state)
                ACCUM:   if (accept && last_tap) state_nxt = HOLD;
                HOLD:    if (y_hs) state_nxt = ACCUM;
                default: state_nxt = ACCUM;
            endcase
        end
    end

    // A product is taken in HOLD only alongside the output handshake, giving zero-bubble frames.
    always_comb begin
        bus.prod_ready = 1'b0;
        bus.y_valid    = (state == HOLD);
        if (!bus.clear)
            bus.prod_ready = (state == ACCUM) || bus.y_ready;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc     <= '0;
            tap_cnt <= '0;
            y_data  <= '0;
        end else if (bus.clear) begin
            acc     <= '0;
            tap_cnt <= '0;
        end else if (accept) begin
            acc <= sum;
            if (last_tap) begin
                tap_cnt <= '0;
                y_data  <= y_nxt;
            end else begin
                tap_cnt <= tap_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.y_data = y_data;
    assign bus.busy   = (tap_cnt != '0);

endmodule

// File: doc/filt_mac_accum.md
Name: filt_mac_accum

Overview:
- Downstream stage of the FIR tap multiplier. It consumes the stream of signed 32-bit tap products and sums NUM_TAPS consecutive products into one filter output sample.
- It presents each completed sample on a valid/ready output port.
- Sits between the product multiplier and the filter output stream interface.

Parameters:
- NUM_TAPS, 11, products summed per output sample (>=2)
- DATA_W, 32, product and output width (two's complement)
- CNT_W, $clog2(NUM_TAPS), tap counter width

Ports:
- ap_clk  input  1  rising-edge clock
- ap_rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous abort: discard partial sum, restart frame
- prod_data  input  DATA_W  signed product from multiplier
- prod_valid  input  1  prod_data valid
- prod_ready  output  1  block accepts prod_data this cycle
- y_data  output  DATA_W  signed filter output sample
- y_valid  output  1  y_data valid
- y_ready  input  1  downstream accepts y_data
- busy  output  1  partial sum in progress (tap_cnt != 0)
- sat_flag  output  1  sticky saturation indicator (ACC_SAT_EN only; tied 0 otherwise)

Behaviour:
- Reset (ap_rst_n=0, asynchronous):
  - state=ACCUM, acc=0, tap_cnt=0
  - y_data=0, y_valid=0, busy=0, sat_flag=0
  - prod_ready=1 after reset release
- States:
  - ACCUM: collecting products
  - HOLD: output sample pending
- Product handshake: a product is taken when prod_valid && prod_ready.
  - prod_ready = (state==ACCUM) || (state==HOLD && y_ready)
- ACCUM, on accept:
  - tap_cnt==0: acc <= prod_data (load, not add)
  - otherwise: acc <= acc + prod_data
  - tap_cnt increments
  - tap_cnt==NUM_TAPS-1: tap_cnt <= 0, y_data <= acc + prod_data, y_valid <= 1, state -> HOLD
  - latency: y_valid rises 1 cycle after the NUM_TAPS-th product is accepted
- HOLD:
  - y_data and y_valid are stable until y_valid && y_ready
  - On the handshake: y_valid <= 0 and state -> ACCUM, unless a product is accepted in the same cycle
- Simultaneous y handshake and product accept in HOLD:
  - The product loads acc as tap 0 of the next frame
  - tap_cnt <= 1, state -> ACCUM
  - No bubble; full throughput is 1 product/cycle.
- Arithmetic:
  - Two's complement, modulo 2^DATA_W (wrap-around), matching the multiplier's truncated 32-bit product.
  - No rounding or scaling.
- clear:
  - Has priority over all other actions.
  - acc=0, tap_cnt=0, state=ACCUM, y_valid=0 on the next edge. A pending y_data is dropped.
  - prod_ready=0 during the clear cycle; a product presented in that cycle is not consumed.
- Idle stall: prod_valid low holds acc and tap_cnt indefinitely. No timeout.
- Reset mid-frame: the partial sum is lost. The next accepted product is tap 0.
- busy=1 iff tap_cnt != 0.

Optional Feature:
- Macro: FILT_ACC_SAT_EN
- Defined:
  - acc is widened to DATA_W+CNT_W+1 bits; products are sign-extended into it.
  - At frame completion the sum is saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1] before loading y_data.
  - Any saturation sets sat_flag, which is sticky until reset or clear.
- Undefined:
  - acc is DATA_W bits and wraps modulo 2^DATA_W.
  - sat_flag is constant 0.

Test Plan:
- Reset, then 11 products of value 1..11, prod_valid held high, y_ready=1 -> y_data=66, y_valid high for 1 cycle, 1 cycle after the 11th accept; busy low afterwards.
- Products all -5 (0xFFFFFFFB) for 11 taps -> y_data=-55 (0xFFFFFFC9).
- Frame done with y_ready=0 for 4 cycles -> y_data=66 stable, prod_ready=0 throughout; then y_ready=1 with prod_valid=1, prod_data=7 -> handshake plus accept in same cycle, tap_cnt=1, next frame of 7 followed by ten 0s gives y_data=7.
- clear asserted after 5 products (1..5) -> busy=0, no y_valid; the following 11 products of 2 -> y_data=22.
- 11 products of 0x7FFFFFFF:
  - without FILT_ACC_SAT_EN -> y_data=0x7FFFFFF5 (wrap), sat_flag=0
  - with FILT_ACC_SAT_EN -> y_data=0x7FFFFFFF, sat_flag=1
- ap_rst_n pulsed low asynchronously mid-frame (after 3 products) -> all outputs 0 immediately; the next 11 products of 1 -> y_data=11.
